bcd_updown_timer: RTL and testbench

//   Parametrised BCD stopwatch/timer core: NUM_DIGITS BCD digits, count-up (stopwatch) or

---
 rtl/bcd_updown_timer.sv | 133 +++++++++++++
 tb/tb_bcd_updown_timer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_updown_timer.sv
// BCD stopwatch/timer core: up/down counting over NUM_DIGITS BCD digits,
// preload with clamping, run/pause control and terminal detection.
module bcd_updown_timer #(
   parameter int NUM_DIGITS = 4,
   parameter int SEC_FORMAT = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic                    mode_up,
   input  logic                    set_time,
   input  logic                    start_stop,
   input  logic                    clear,
   input  logic [4*NUM_DIGITS-1:0] load_digits,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    running,
   output logic                    done,
   output logic                    at_limit
);

   localparam int W = 4 * NUM_DIGITS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Digit 1 is tens-of-seconds in MM:SS mode and tops out at 5.
   function automatic logic [3:0] digit_lim(input int i);
      return (SEC_FORMAT != 0 && i == 1) ? 4'd5 : 4'd9;
   endfunction

   function automatic logic [W-1:0] max_val();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         v[4*i +: 4] = digit_lim(i);
      end
      return v;
   endfunction

   localparam logic [W-1:0] MAX = max_val();

   logic [1:0]   state;
   logic         dir_q;
   logic [W-1:0] inc_v;
   logic [W-1:0] dec_v;
   logic [W-1:0] clamp_v;
   logic [W-1:0] nxt;
   logic         nxt_term;
   logic         start_lim;

   // Full carry/borrow ripple across every digit in one cycle.
   always_comb begin
      logic cy;
      logic bw;
      inc_v   = count;
      dec_v   = count;
      clamp_v = load_digits;
      cy      = 1'b1;
      bw      = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (cy) begin
            if (count[4*i +: 4] >= digit_lim(i)) begin
               inc_v[4*i +: 4] = 4'd0;
            end else begin
               inc_v[4*i +: 4] = count[4*i +: 4] + 4'd1;
               cy = 1'b0;
            end
         end
         if (bw) begin
            if (count[4*i +: 4] == 4'd0) begin
               dec_v[4*i +: 4] = digit_lim(i);
            end else begin
               dec_v[4*i +: 4] = count[4*i +: 4] - 4'd1;
               bw = 1'b0;
            end
         end
         if (load_digits[4*i +: 4] > digit_lim(i)) begin
            clamp_v[4*i +: 4] = digit_lim(i);
         end
      end
   end

   assign nxt       = dir_q ? inc_v : dec_v;
   assign nxt_term  = dir_q ? (inc_v == MAX) : (dec_v == '0);
   assign start_lim = mode_up ? (count == MAX) : (count == '0);
   assign at_limit  = dir_q ? (count == MAX) : (count == '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         count   <= '0;
         state   <= ST_IDLE;
         running <= 1'b0;
         done    <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (clear) begin
            count   <= '0;
            state   <= ST_IDLE;
            running <= 1'b0;
         end else if (set_time && state != ST_RUN) begin
            count   <= clamp_v;
            state   <= ST_IDLE;
            running <= 1'b0;
         end else if (start_stop) begin
            case (state)
               ST_IDLE, ST_PAUSE: begin
                  if (!start_lim) begin
                     state   <= ST_RUN;
                     running <= 1'b1;
                     dir_q   <= mode_up;
                  end
               end
               ST_RUN: begin
                  state   <= ST_PAUSE;
                  running <= 1'b0;
               end
               default: ;
            endcase
         end else if (tick && state == ST_RUN) begin
            count <= nxt;
            if (nxt_term) begin
               state   <= ST_DONE;
               running <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_bcd_updown_timer.sv
// Directed bench for bcd_updown_timer: MM:SS 4-digit instance plus a
// plain-decimal 2-digit instance sharing the control pulses.
module tb_bcd_updown_timer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        tick = 1'b0;
   logic        set_time = 1'b0;
   logic        start_stop = 1'b0;
   logic        clear = 1'b0;
   logic        mode_up = 1'b0;
   logic [15:0] load_digits = '0;
   logic [15:0] count;
   logic        running;
   logic        done;
   logic        at_limit;

   logic        mode_up2 = 1'b0;
   logic [7:0]  load2 = '0;
   logic [7:0]  count2;
   logic        running2;
   logic        done2;
   logic        at_limit2;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   bcd_updown_timer #(.NUM_DIGITS(4), .SEC_FORMAT(1)) dut (
      .clk(clk), .reset(reset), .tick(tick), .mode_up(mode_up),
      .set_time(set_time), .start_stop(start_stop), .clear(clear),
      .load_digits(load_digits), .count(count), .running(running),
      .done(done), .at_limit(at_limit)
   );

   bcd_updown_timer #(.NUM_DIGITS(2), .SEC_FORMAT(0)) dut2 (
      .clk(clk), .reset(reset), .tick(tick), .mode_up(mode_up2),
      .set_time(set_time), .start_stop(start_stop), .clear(clear),
      .load_digits(load2), .count(count2), .running(running2),
      .done(done2), .at_limit(at_limit2)
   );

   // Inputs change at negedge, are sampled on the next posedge, and
   // outputs are observed at the following negedge.
   task automatic step(input logic st, input logic ss,
                       input logic cl, input logic tk);
      set_time = st;
      start_stop = ss;
      clear = cl;
      tick = tk;
      @(negedge clk);
      set_time = 1'b0;
      start_stop = 1'b0;
      clear = 1'b0;
      tick = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step(0, 0, 0, 0);
      reset = 1'b0;
      n_cmp++;
      if (count !== 16'h0000) begin
         n_bad++; $display("FAIL reset_count: got %h want 0000", count);
      end
      n_cmp++;
      if (running !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL reset_flags: got run=%b done=%b want 0 0", running, done);
      end
      n_cmp++;
      if (at_limit !== 1'b1) begin
         n_bad++; $display("FAIL reset_at_limit: got %b want 1", at_limit);
      end
   endtask

   task automatic test_countdown();
      int dones;
      dones = 0;
      mode_up = 1'b0;
      load_digits = 16'h0102;
      step(1, 0, 0, 0);
      n_cmp++;
      if (count !== 16'h0102) begin
         n_bad++; $display("FAIL dn_load: got %h want 0102", count);
      end
      step(0, 1, 0, 0);
      n_cmp++;
      if (running !== 1'b1) begin
         n_bad++; $display("FAIL dn_start: got %b want 1", running);
      end
      for (int k = 1; k <= 62; k++) begin
         step(0, 0, 0, 1);
         if (done === 1'b1) dones++;
         if (k == 1) begin
            n_cmp++;
            if (count !== 16'h0101) begin
               n_bad++; $display("FAIL dn_t1: got %h want 0101", count);
            end
         end
         if (k == 2) begin
            n_cmp++;
            if (count !== 16'h0100) begin
               n_bad++; $display("FAIL dn_t2: got %h want 0100", count);
            end
         end
         if (k == 3) begin
            n_cmp++;
            if (count !== 16'h0059) begin
               n_bad++; $display("FAIL dn_t3: got %h want 0059", count);
            end
         end
         if (k == 62) begin
            n_cmp++;
            if (done !== 1'b1) begin
               n_bad++; $display("FAIL dn_done_pulse: got %b want 1", done);
            end
         end
      end
      n_cmp++;
      if (count !== 16'h0000 || running !== 1'b0) begin
         n_bad++; $display("FAIL dn_end: got %h run=%b want 0000 run=0", count, running);
      end
      step(0, 0, 0, 0);
      n_cmp++;
      if (done !== 1'b0 || dones != 1) begin
         n_bad++; $display("FAIL dn_done_once: got done=%b pulses=%0d want 0 1", done, dones);
      end
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      n_cmp++;
      if (count !== 16'h0000 || running !== 1'b0) begin
         n_bad++; $display("FAIL dn_hold: got %h run=%b want 0000 run=0", count, running);
      end
   endtask

   task automatic test_up();
      mode_up = 1'b1;
      load_digits = 16'h0959;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      n_cmp++;
      if (count !== 16'h1000) begin
         n_bad++; $display("FAIL up_carry: got %h want 1000", count);
      end
      step(0, 1, 0, 0);
      load_digits = 16'h9958;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      n_cmp++;
      if (count !== 16'h9959 || done !== 1'b1 || running !== 1'b0) begin
         n_bad++; $display("FAIL up_term: got %h done=%b run=%b want 9959 1 0", count, done, running);
      end
      n_cmp++;
      if (at_limit !== 1'b1) begin
         n_bad++; $display("FAIL up_at_limit: got %b want 1", at_limit);
      end
      step(0, 0, 0, 1);
      step(0, 1, 0, 0);
      n_cmp++;
      if (count !== 16'h9959 || running !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL up_hold: got %h run=%b done=%b want 9959 0 0", count, running, done);
      end
   endtask

   task automatic test_clamp();
      load_digits = 16'h0F7A;
      step(1, 0, 0, 0);
      n_cmp++;
      if (count !== 16'h0959) begin
         n_bad++; $display("FAIL clamp: got %h want 0959", count);
      end
      step(0, 0, 1, 0);
      mode_up = 1'b0;
      step(0, 1, 0, 0);
      n_cmp++;
      if (count !== 16'h0000 || running !== 1'b0) begin
         n_bad++; $display("FAIL start_at_zero: got %h run=%b want 0000 run=0", count, running);
      end
   endtask

   task automatic test_pause();
      load_digits = 16'h0010;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 1);
      n_cmp++;
      if (count !== 16'h0010 || running !== 1'b0) begin
         n_bad++; $display("FAIL pause_tick: got %h run=%b want 0010 run=0", count, running);
      end
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      n_cmp++;
      if (count !== 16'h0009 || running !== 1'b1) begin
         n_bad++; $display("FAIL resume: got %h run=%b want 0009 run=1", count, running);
      end
   endtask

   task automatic test_set_in_run();
      load_digits = 16'h0300;
      step(1, 0, 0, 0);
      n_cmp++;
      if (count !== 16'h0009 || running !== 1'b1) begin
         n_bad++; $display("FAIL set_in_run: got %h run=%b want 0009 run=1", count, running);
      end
      step(1, 0, 0, 1);
      n_cmp++;
      if (count !== 16'h0008) begin
         n_bad++; $display("FAIL set_tick_run: got %h want 0008", count);
      end
      step(0, 1, 0, 0);
      load_digits = 16'h0500;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      n_cmp++;
      if (count !== 16'h0459) begin
         n_bad++; $display("FAIL borrow_ripple: got %h want 0459", count);
      end
   endtask

   task automatic test_abort();
      step(0, 1, 0, 0);
      load_digits = 16'h0345;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      reset = 1'b1;
      step(0, 0, 0, 1);
      reset = 1'b0;
      n_cmp++;
      if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid_run: got %h run=%b done=%b want 0000 0 0", count, running, done);
      end
      load_digits = 16'h0001;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      n_cmp++;
      if (count !== 16'h0000 || done !== 1'b1) begin
         n_bad++; $display("FAIL reach_done: got %h done=%b want 0000 1", count, done);
      end
      step(0, 0, 1, 0);
      n_cmp++;
      if (count !== 16'h0000 || running !== 1'b0 || done !== 1'b0) begin
         n_bad++; $display("FAIL clear_done: got %h run=%b done=%b want 0000 0 0", count, running, done);
      end
      load_digits = 16'h0002;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      n_cmp++;
      if (running !== 1'b1) begin
         n_bad++; $display("FAIL restart_after_clear: got %b want 1", running);
      end
   endtask

   task automatic test_decimal();
      step(0, 0, 1, 0);
      mode_up2 = 1'b1;
      load2 = 8'h09;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      n_cmp++;
      if (count2 !== 8'h10) begin
         n_bad++; $display("FAIL dec_up: got %h want 10", count2);
      end
      step(0, 1, 0, 0);
      mode_up2 = 1'b0;
      load2 = 8'h10;
      step(1, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 0, 0, 1);
      n_cmp++;
      if (count2 !== 8'h09) begin
         n_bad++; $display("FAIL dec_down: got %h want 09", count2);
      end
      load2 = 8'hC7;
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      n_cmp++;
      if (count2 !== 8'h97) begin
         n_bad++; $display("FAIL dec_clamp: got %h want 97", count2);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_countdown();
      test_up();
      test_clamp();
      test_pause();
      test_set_in_run();
      test_abort();
      test_decimal();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
